// File: rtl/ecap5_dproc_pkg.sv
// Shared types for the Wishbone arbiter.
// Grant encoding and requester count.
package ecap5_dproc_pkg;

    localparam int NB_REQUESTERS = 2;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_M0   = 2'd1,
        GRANT_M1   = 2'd2
    } grant_t;

endpackage

// File: rtl/wb_arbiter.sv
// Two-requester pipelined Wishbone arbiter.
// Grants per cyc frame and tracks outstanding requests.
module wb_arbiter
    import ecap5_dproc_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RR_ENABLE       = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic [ADDR_WIDTH-1:0]   m0_wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m0_wb_sel_i,
    input  logic                    m0_wb_we_i,
    input  logic                    m0_wb_stb_i,
    input  logic                    m0_wb_cyc_i,
    output logic [DATA_WIDTH-1:0]   m0_wb_dat_o,
    output logic                    m0_wb_ack_o,
    output logic                    m0_wb_stall_o,

    input  logic [ADDR_WIDTH-1:0]   m1_wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m1_wb_sel_i,
    input  logic                    m1_wb_we_i,
    input  logic                    m1_wb_stb_i,
    input  logic                    m1_wb_cyc_i,
    output logic [DATA_WIDTH-1:0]   m1_wb_dat_o,
    output logic                    m1_wb_ack_o,
    output logic                    m1_wb_stall_o,

    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic                    wb_we_o,
    output logic                    wb_stb_o,
    output logic                    wb_cyc_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_stall_i
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int SEL_W = DATA_WIDTH / 8;

    grant_t             r_grant;
    grant_t             r_last;
    logic [CNT_W-1:0]   r_outstanding;

    logic               w_req0;
    logic               w_req1;
    logic               w_own0;
    logic               w_own1;
    logic               w_full;
    logic               w_accept;
    logic               w_ack_ok;
    logic [CNT_W-1:0]   w_cnt_next;

    assign w_req0   = m0_wb_cyc_i & m0_wb_stb_i;
    assign w_req1   = m1_wb_cyc_i & m1_wb_stb_i;
    assign w_own0   = (r_grant == GRANT_M0);
    assign w_own1   = (r_grant == GRANT_M1);
    assign w_full   = (r_outstanding == CNT_W'(MAX_OUTSTANDING));
    assign w_accept = wb_cyc_o & wb_stb_o & ~wb_stall_i;
    assign w_ack_ok = wb_ack_i & wb_cyc_o & (r_grant != GRANT_NONE)
                    & (r_outstanding != '0);

    // Route the owner's request onto the bus; idle bus when nobody owns it.
    always_comb begin
        wb_adr_o = '0;
        wb_dat_o = '0;
        wb_sel_o = '0;
        wb_we_o  = 1'b0;
        wb_stb_o = 1'b0;
        wb_cyc_o = 1'b0;
        unique case (r_grant)
            GRANT_M0: begin
                wb_adr_o = m0_wb_adr_i;
                wb_dat_o = m0_wb_dat_i;
                wb_sel_o = m0_wb_sel_i;
                wb_we_o  = m0_wb_we_i;
                wb_stb_o = m0_wb_stb_i & ~w_full;
                wb_cyc_o = m0_wb_cyc_i;
            end
            GRANT_M1: begin
                wb_adr_o = m1_wb_adr_i;
                wb_dat_o = m1_wb_dat_i;
                wb_sel_o = m1_wb_sel_i;
                wb_we_o  = m1_wb_we_i;
                wb_stb_o = m1_wb_stb_i & ~w_full;
                wb_cyc_o = m1_wb_cyc_i;
            end
            default: ;
        endcase
    end

    // Return path: only the owner sees ack, data and a live stall.
    always_comb begin
        m0_wb_ack_o   = wb_ack_i & w_own0 & wb_cyc_o;
        m1_wb_ack_o   = wb_ack_i & w_own1 & wb_cyc_o;
        m0_wb_dat_o   = w_own0 ? wb_dat_i : '0;
        m1_wb_dat_o   = w_own1 ? wb_dat_i : '0;
        m0_wb_stall_o = w_own0 ? (wb_stall_i | w_full) : 1'b1;
        m1_wb_stall_o = w_own1 ? (wb_stall_i | w_full) : 1'b1;
    end

    // Outstanding count; accept and ack in one cycle cancel out.
    always_comb begin
        w_cnt_next = r_outstanding;
        if (w_accept && !w_ack_ok) begin
            w_cnt_next = r_outstanding + CNT_W'(1);
        end else if (!w_accept && w_ack_ok) begin
            w_cnt_next = r_outstanding - CNT_W'(1);
        end
    end

    // Grant FSM: one NONE cycle between owners, release when cyc drops.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_grant       <= GRANT_NONE;
            r_last        <= GRANT_M0;
            r_outstanding <= '0;
        end else begin
            unique case (r_grant)
                GRANT_NONE: begin
                    r_outstanding <= '0;
                    if (w_req0 && w_req1) begin
                        if (RR_ENABLE != 0) begin
                            r_grant <= (r_last == GRANT_M0) ?
                                       GRANT_M1 : GRANT_M0;
                        end else begin
                            r_grant <= GRANT_M1;
                        end
                    end else if (w_req1) begin
                        r_grant <= GRANT_M1;
                    end else if (w_req0) begin
                        r_grant <= GRANT_M0;
                    end
                end
                GRANT_M0: begin
                    if (!m0_wb_cyc_i) begin
                        r_grant       <= GRANT_NONE;
                        r_last        <= GRANT_M0;
                        r_outstanding <= '0;
                    end else begin
                        r_outstanding <= w_cnt_next;
                    end
                end
                GRANT_M1: begin
                    if (!m1_wb_cyc_i) begin
                        r_grant       <= GRANT_NONE;
                        r_last        <= GRANT_M1;
                        r_outstanding <= '0;
                    end else begin
                        r_outstanding <= w_cnt_next;
                    end
                end
                default: begin
                    r_grant       <= GRANT_NONE;
                    r_outstanding <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter.
// Second instance runs fixed priority on the same stimulus.
module tb_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;

    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc;
    logic [31:0] m0_dato, m1_dato;
    logic        m0_ack, m0_stall, m1_ack, m1_stall;
    logic [31:0] wb_adr, wb_dato;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_stb, wb_cyc;
    logic [31:0] wb_dati;
    logic        wb_ack, wb_stall;

    logic [31:0] fp_m0_dato, fp_m1_dato;
    logic        fp_m0_ack, fp_m0_stall, fp_m1_ack, fp_m1_stall;
    logic [31:0] fp_wb_adr, fp_wb_dato;
    logic [3:0]  fp_wb_sel;
    logic        fp_wb_we, fp_wb_stb, fp_wb_cyc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    wb_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .MAX_OUTSTANDING(4), .RR_ENABLE(1)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_dat),
        .m0_wb_sel_i(m0_sel), .m0_wb_we_i(m0_we),
        .m0_wb_stb_i(m0_stb), .m0_wb_cyc_i(m0_cyc),
        .m0_wb_dat_o(m0_dato), .m0_wb_ack_o(m0_ack),
        .m0_wb_stall_o(m0_stall),
        .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat),
        .m1_wb_sel_i(m1_sel), .m1_wb_we_i(m1_we),
        .m1_wb_stb_i(m1_stb), .m1_wb_cyc_i(m1_cyc),
        .m1_wb_dat_o(m1_dato), .m1_wb_ack_o(m1_ack),
        .m1_wb_stall_o(m1_stall),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dato), .wb_sel_o(wb_sel),
        .wb_we_o(wb_we), .wb_stb_o(wb_stb), .wb_cyc_o(wb_cyc),
        .wb_dat_i(wb_dati), .wb_ack_i(wb_ack), .wb_stall_i(wb_stall)
    );

    wb_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .MAX_OUTSTANDING(4), .RR_ENABLE(0)
    ) dut_fp (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_dat),
        .m0_wb_sel_i(m0_sel), .m0_wb_we_i(m0_we),
        .m0_wb_stb_i(m0_stb), .m0_wb_cyc_i(m0_cyc),
        .m0_wb_dat_o(fp_m0_dato), .m0_wb_ack_o(fp_m0_ack),
        .m0_wb_stall_o(fp_m0_stall),
        .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat),
        .m1_wb_sel_i(m1_sel), .m1_wb_we_i(m1_we),
        .m1_wb_stb_i(m1_stb), .m1_wb_cyc_i(m1_cyc),
        .m1_wb_dat_o(fp_m1_dato), .m1_wb_ack_o(fp_m1_ack),
        .m1_wb_stall_o(fp_m1_stall),
        .wb_adr_o(fp_wb_adr), .wb_dat_o(fp_wb_dato), .wb_sel_o(fp_wb_sel),
        .wb_we_o(fp_wb_we), .wb_stb_o(fp_wb_stb), .wb_cyc_o(fp_wb_cyc),
        .wb_dat_i(wb_dati), .wb_ack_i(wb_ack), .wb_stall_i(wb_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b0;
        m0_adr = 32'h0000_1000; m0_dat = 32'h0; m0_sel = 4'hF;
        m0_we = 1'b0; m0_stb = 1'b1; m0_cyc = 1'b1;
        m1_adr = 32'h0; m1_dat = 32'h0; m1_sel = 4'hF;
        m1_we = 1'b0; m1_stb = 1'b0; m1_cyc = 1'b0;
        wb_dati = 32'h0; wb_ack = 1'b0; wb_stall = 1'b0;

        // Reset held with M0 requesting
        step(); step();
        #1;
        chk("rst_cyc", 32'(wb_cyc), 32'h0);
        chk("rst_stb", 32'(wb_stb), 32'h0);
        chk("rst_m0_stall", 32'(m0_stall), 32'h1);
        chk("rst_m1_stall", 32'(m1_stall), 32'h1);
        chk("rst_m0_dat", m0_dato, 32'h0);
        step();
        rst_i = 1'b1;
        #1;
        chk("rel_stb_pre", 32'(wb_stb), 32'h0);
        step();
        #1;
        chk("rel_stb", 32'(wb_stb), 32'h1);
        chk("rel_adr", wb_adr, 32'h0000_1000);
        chk("rel_m0_stall", 32'(m0_stall), 32'h0);
        step();
        m0_stb = 1'b0; wb_ack = 1'b1; wb_dati = 32'h1111_1111;
        #1;
        chk("m0_ack", 32'(m0_ack), 32'h1);
        chk("m0_dat", m0_dato, 32'h1111_1111);
        step();
        wb_ack = 1'b0; m0_cyc = 1'b0;
        #1;
        chk("m0_rel_cyc", 32'(wb_cyc), 32'h0);
        step();

        // Single M1 read
        m1_adr = 32'h2000_0004; m1_cyc = 1'b1; m1_stb = 1'b1;
        #1;
        chk("m1_wait_stall", 32'(m1_stall), 32'h1);
        chk("m1_wait_stb", 32'(wb_stb), 32'h0);
        step();
        #1;
        chk("m1_stb", 32'(wb_stb), 32'h1);
        chk("m1_adr", wb_adr, 32'h2000_0004);
        chk("m1_we", 32'(wb_we), 32'h0);
        chk("m1_stall", 32'(m1_stall), 32'h0);
        step();
        m1_stb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("m1_noack", 32'(m1_ack), 32'h0);
            step();
        end
        wb_ack = 1'b1; wb_dati = 32'hDEAD_BEEF;
        #1;
        chk("m1_ack", 32'(m1_ack), 32'h1);
        chk("m1_dat", m1_dato, 32'hDEAD_BEEF);
        chk("m1_m0_ack", 32'(m0_ack), 32'h0);
        chk("m1_m0_dat", m0_dato, 32'h0);
        step();
        wb_ack = 1'b0;
        #1;
        chk("m1_ack_once", 32'(m1_ack), 32'h0);
        m1_cyc = 1'b0;
        step();

        // Simultaneous requests from reset
        rst_i = 1'b0;
        m0_adr = 32'h0000_1000; m0_cyc = 1'b1; m0_stb = 1'b1;
        m1_adr = 32'h0000_3000; m1_cyc = 1'b1; m1_stb = 1'b1;
        step(); step();
        rst_i = 1'b1;
        step();
        #1;
        chk("rr_first_adr", wb_adr, 32'h0000_3000);
        chk("rr_first_m0_stall", 32'(m0_stall), 32'h1);
        chk("rr_first_m1_stall", 32'(m1_stall), 32'h0);
        chk("fp_first_adr", fp_wb_adr, 32'h0000_3000);
        step();
        m1_stb = 1'b0; wb_ack = 1'b1; wb_dati = 32'h0000_0055;
        #1;
        chk("rr_m1_ack", 32'(m1_ack), 32'h1);
        chk("rr_m1_dat", m1_dato, 32'h0000_0055);
        step();
        wb_ack = 1'b0; m1_cyc = 1'b0;
        #1;
        chk("rr_m1_rel_cyc", 32'(wb_cyc), 32'h0);
        step();
        m1_cyc = 1'b1; m1_stb = 1'b1;
        #1;
        chk("rr_none_cyc", 32'(wb_cyc), 32'h0);
        chk("rr_none_m0_stall", 32'(m0_stall), 32'h1);
        chk("rr_none_m1_stall", 32'(m1_stall), 32'h1);
        step();
        #1;
        chk("rr_second_adr", wb_adr, 32'h0000_1000);
        chk("rr_second_m0_stall", 32'(m0_stall), 32'h0);
        chk("rr_second_m1_stall", 32'(m1_stall), 32'h1);
        chk("fp_second_adr", fp_wb_adr, 32'h0000_3000);
        chk("fp_second_m1_stall", 32'(fp_m1_stall), 32'h0);
        chk("fp_second_m0_stall", 32'(fp_m0_stall), 32'h1);

        // Mid-transaction reset drops cyc asynchronously
        rst_i = 1'b0;
        #1;
        chk("midrst_cyc", 32'(wb_cyc), 32'h0);
        chk("midrst_m0_stall", 32'(m0_stall), 32'h1);
        chk("midrst_fp_cyc", 32'(fp_wb_cyc), 32'h0);

        // Pipelined burst of 6 writes against a limit of 4
        m1_cyc = 1'b0; m1_stb = 1'b0;
        m0_we = 1'b1; m0_dat = 32'hA0; m0_adr = 32'h100;
        step(); step();
        rst_i = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            m0_adr = 32'h100 + 32'(4 * k);
            m0_dat = 32'hA0 + 32'(k);
            #1;
            chk("burst_stall", 32'(m0_stall), 32'h0);
            chk("burst_adr", wb_adr, 32'h100 + 32'(4 * k));
            step();
        end
        m0_adr = 32'h110; m0_dat = 32'hA4;
        #1;
        chk("burst_full_stall", 32'(m0_stall), 32'h1);
        chk("burst_full_stb", 32'(wb_stb), 32'h0);
        wb_ack = 1'b1; wb_dati = 32'hD0;
        #1;
        chk("burst_ack0", 32'(m0_ack), 32'h1);
        chk("burst_dat0", m0_dato, 32'hD0);
        step();
        wb_ack = 1'b0; wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bstall_stall", 32'(m0_stall), 32'h1);
            chk("bstall_adr", wb_adr, 32'h110);
            chk("bstall_dat", wb_dato, 32'hA4);
            chk("bstall_stb", 32'(wb_stb), 32'h1);
            step();
        end
        wb_stall = 1'b0;
        #1;
        chk("bstall_rel", 32'(m0_stall), 32'h0);
        chk("bstall_rel_adr", wb_adr, 32'h110);
        chk("bstall_rel_we", 32'(wb_we), 32'h1);
        step();
        m0_adr = 32'h114; m0_dat = 32'hA5;
        #1;
        chk("burst_full2", 32'(m0_stall), 32'h1);
        wb_ack = 1'b1; wb_dati = 32'hD1;
        #1;
        chk("burst_ack1", 32'(m0_ack), 32'h1);
        step();
        wb_ack = 1'b0;
        #1;
        chk("burst_6th_stall", 32'(m0_stall), 32'h0);
        chk("burst_6th_adr", wb_adr, 32'h114);
        step();
        m0_stb = 1'b0;
        #1;
        chk("burst_full3", 32'(m0_stall), 32'h1);
        for (int j = 0; j < 4; j++) begin
            wb_ack = 1'b1; wb_dati = 32'hD2 + 32'(j);
            #1;
            chk("burst_ackn", 32'(m0_ack), 32'h1);
            chk("burst_datn", m0_dato, 32'hD2 + 32'(j));
            step();
        end
        wb_ack = 1'b0;

        // Abort with 2 outstanding while M1 waits
        m0_stb = 1'b1; m0_adr = 32'h200;
        step();
        m0_adr = 32'h204;
        step();
        m0_stb = 1'b0; m0_cyc = 1'b0;
        m1_adr = 32'h4000; m1_we = 1'b0; m1_cyc = 1'b1; m1_stb = 1'b1;
        #1;
        chk("abort_cyc", 32'(wb_cyc), 32'h0);
        chk("abort_m1_stall", 32'(m1_stall), 32'h1);
        step();
        wb_ack = 1'b1; wb_dati = 32'hBAD0_BAD0;
        #1;
        chk("late_m0_ack", 32'(m0_ack), 32'h0);
        chk("late_m1_ack", 32'(m1_ack), 32'h0);
        chk("late_m0_dat", m0_dato, 32'h0);
        chk("late_m1_dat", m1_dato, 32'h0);
        chk("late_cyc", 32'(wb_cyc), 32'h0);
        step();
        wb_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m1_adr = 32'h4000 + 32'(4 * k);
            #1;
            chk("m1_after_abort_stall", 32'(m1_stall), 32'h0);
            chk("m1_after_abort_adr", wb_adr, 32'h4000 + 32'(4 * k));
            step();
        end
        #1;
        chk("m1_after_abort_full", 32'(m1_stall), 32'h1);
        chk("m1_after_abort_stb", 32'(wb_stb), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the core's single pipelined Wishbone master port between two internal requesters: M0 (instruction fetch) and M1 (load/store).
- Sits between the two units and the top-level wb_* pins.
- Grants the bus per Wishbone cycle (cyc-framed), routes stall/ack/data back to the owner and tracks outstanding requests so ownership never changes with acks in flight.

Parameters:
- ADDR_WIDTH, 32, address width on all ports.
- DATA_WIDTH, 32, data width; sel width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 4, maximum accepted-but-unacked requests per cycle; counter width is $clog2(MAX_OUTSTANDING+1).
- RR_ENABLE, 1, 1 = round-robin between M0/M1; 0 = fixed priority, M1 wins.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low (asserted when 0).
- mN_wb_adr_i  in  ADDR_WIDTH  requester N address (N = 0, 1; same for all mN_* below).
- mN_wb_dat_i  in  DATA_WIDTH  requester N write data.
- mN_wb_sel_i  in  DATA_WIDTH/8  requester N byte select.
- mN_wb_we_i  in  1  requester N write enable.
- mN_wb_stb_i  in  1  requester N strobe.
- mN_wb_cyc_i  in  1  requester N cycle.
- mN_wb_dat_o  out  DATA_WIDTH  read data to requester N.
- mN_wb_ack_o  out  1  ack to requester N.
- mN_wb_stall_o  out  1  stall to requester N.
- wb_adr_o  out  ADDR_WIDTH  bus address.
- wb_dat_o  out  DATA_WIDTH  bus write data.
- wb_sel_o  out  DATA_WIDTH/8  bus byte select.
- wb_we_o  out  1  bus write enable.
- wb_stb_o  out  1  bus strobe.
- wb_cyc_o  out  1  bus cycle.
- wb_dat_i  in  DATA_WIDTH  bus read data.
- wb_ack_i  in  1  bus ack.
- wb_stall_i  in  1  bus stall.

Behaviour:
- Registered state: grant_q ∈ {NONE, M0, M1}, last_q (last granted requester, for round-robin), outstanding_q.
- Reset (rst_i = 0, async) and reset mid-transaction: grant_q = NONE, last_q = M0, outstanding_q = 0.
  - Bus outputs all 0.
  - mN_ack_o = 0, mN_stall_o = 1, mN_dat_o = 0.
  - A mid-transaction reset abandons the transaction; the bus sees cyc fall asynchronously.
- Grant state machine, evaluated each rising edge:
  - NONE: if exactly one mN_cyc_i & mN_stb_i, grant_q <= that N. If both:
    - RR_ENABLE = 1: grant the one that is not last_q.
    - RR_ENABLE = 0: grant M1.
    - Otherwise stay NONE.
  - MN: stay while mN_cyc_i = 1. When mN_cyc_i = 0: grant_q <= NONE, last_q <= N, outstanding_q <= 0. No direct MN→MK transition; one NONE cycle between owners is required.
- Grant latency: request visible in cycle T gives bus stb in cycle T+1. The requester holds stb because its stall_o was 1 in cycle T.
- Bus muxing (combinational from grant_q):
  - wb_* outputs = granted requester's inputs; all 0 when NONE.
  - wb_cyc_o = mN_cyc_i of the owner.
- Stall:
  - Non-owner stall_o = 1.
  - Owner stall_o = wb_stall_i | (outstanding_q == MAX_OUTSTANDING).
  - wb_stb_o is forced 0 while the outstanding limit is hit.
- Accept: accepted = wb_cyc_o & wb_stb_o & ~wb_stall_i.
- Outstanding counter: +1 on accept, −1 on ack, unchanged when both happen in the same cycle. Never exceeds MAX_OUTSTANDING; never underflows.
- Ack routing: mN_ack_o = wb_ack_i & (grant_q == MN) & wb_cyc_o.
  - mN_dat_o = wb_dat_i for the owner, 0 otherwise.
  - Ack with outstanding_q = 0, or while NONE, is dropped and the counter is not decremented.
- Owner drops cyc with outstanding_q > 0: this is a Wishbone abort. Release as above; later acks are dropped.
- Combinational paths: only input-to-output through the mux. No state depends combinationally on wb_ack_i.

Decomposition:
- ecap5_dproc_pkg: grant_t enum (GRANT_NONE, GRANT_M0, GRANT_M1) and localparam NB_REQUESTERS = 2.
- No sub-module; the outstanding counter stays inline.

Test Plan:
- Reset: hold rst_i = 0 with m0 cyc/stb = 1 → wb_cyc_o = 0, m0_stall_o = 1. After release, wb_stb_o = 1 one cycle later with wb_adr_o = m0_wb_adr_i (e.g. 0x0000_1000).
- Single M1 read at 0x2000_0004, ack after 3 cycles with wb_dat_i = 0xDEADBEEF → m1_ack_o pulses once, m1_wb_dat_o = 0xDEADBEEF, m0_ack_o stays 0.
- Simultaneous M0/M1 requests from reset, RR_ENABLE = 1 → M1 granted first (last_q = M0). After M1 drops cyc, one NONE cycle, then M0 granted. With RR_ENABLE = 0 and M1 re-requesting, M1 wins again.
- Pipelined burst: M0 issues 6 stb back-to-back, slave withholds acks, MAX_OUTSTANDING = 4 → exactly 4 accepted, m0_stall_o = 1 in cycle 5. Each ack admits one more; all 6 acked in order.
- wb_stall_i = 1 for 3 cycles mid-burst → m0_stall_o mirrors it, adr/dat stable, outstanding_q unchanged.
- Abort: M0 drops cyc with 2 outstanding, M1 waiting → M1 granted after one NONE cycle; a late wb_ack_i during NONE reaches neither requester.
